parity_frame_accumulator: RTL and testbench

//   Parametrised, sequential successor to the 4-bit odd-parity checker.

---
 rtl/parity_frame_accumulator.sv | 130 +++++++++++++
 tb/tb_parity_frame_accumulator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_accumulator.sv
// Column-XOR parity over frames of up to FRAME_LEN words; optional PARITY_ONES_COUNT_EN adds onesCount.
// Result is registered one cycle after the last word; inReady drops while the result waits in HOLD.
module parity_frame_accumulator #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  inData,
    input  logic                               inValid,
    input  logic                               inLast,
    input  logic                               oddMode,
    output logic                               inReady,
    output logic [DATA_W-1:0]                  colParity,
    output logic                               parityBit,
    output logic [$clog2(FRAME_LEN+1)-1:0]     wordCount,
    output logic                               outValid,
    input  logic                               outReady
`ifdef PARITY_ONES_COUNT_EN
    ,
    output logic [$clog2(DATA_W*FRAME_LEN+1)-1:0] onesCount
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q, acc_d, col_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, wc_q;
    logic              mode_q, mode_d, par_q;
    logic              in_rdy_q, out_vld_q;
    logic              first, accept, frame_end;

`ifdef PARITY_ONES_COUNT_EN
    localparam int ONES_W = $clog2(DATA_W * FRAME_LEN + 1);

    logic [ONES_W-1:0] ones_q, ones_d, ones_out_q;

    function automatic logic [ONES_W-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + ONES_W'(d[i]);
        end
        return c;
    endfunction

    always_comb begin
        ones_d = first ? popcount(inData) : ones_q + popcount(inData);
    end

    assign onesCount = ones_out_q;
`endif

    // The first word of a frame restarts the accumulator and latches the mode.
    always_comb begin
        first     = (state_q == IDLE);
        accept    = inValid && in_rdy_q;
        acc_d     = first ? inData : (acc_q ^ inData);
        cnt_d     = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
        mode_d    = first ? oddMode : mode_q;
        frame_end = inLast || (cnt_d == FRAME_LEN_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            col_q     <= '0;
            par_q     <= 1'b0;
            wc_q      <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
`ifdef PARITY_ONES_COUNT_EN
            ones_q     <= '0;
            ones_out_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q  <= acc_d;
                        cnt_q  <= cnt_d;
                        mode_q <= mode_d;
`ifdef PARITY_ONES_COUNT_EN
                        ones_q <= ones_d;
`endif
                        if (frame_end) begin
                            state_q   <= HOLD;
                            col_q     <= acc_d;
                            par_q     <= mode_d ? ^acc_d : ~^acc_d;
                            wc_q      <= cnt_d;
                            out_vld_q <= 1'b1;
                            in_rdy_q  <= 1'b0;
`ifdef PARITY_ONES_COUNT_EN
                            ones_out_q <= ones_d;
`endif
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        state_q   <= IDLE;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign inReady   = in_rdy_q;
    assign outValid  = out_vld_q;
    assign colParity = col_q;
    assign parityBit = par_q;
    assign wordCount = wc_q;

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// Directed and randomized frames against a queue-based reference model.
module tb_parity_frame_accumulator;

    localparam int DW = 4;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] inData;
    logic          inValid, inLast, oddMode, inReady;
    logic [DW-1:0] colParity;
    logic          parityBit;
    logic [2:0]    wordCount;
    logic          outValid, outReady;
`ifdef PARITY_ONES_COUNT_EN
    logic [4:0]    onesCount;
`endif

    always #5 clk = ~clk;

    parity_frame_accumulator #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .reset     (reset),
        .inData    (inData),
        .inValid   (inValid),
        .inLast    (inLast),
        .oddMode   (oddMode),
        .inReady   (inReady),
        .colParity (colParity),
        .parityBit (parityBit),
        .wordCount (wordCount),
        .outValid  (outValid),
        .outReady  (outReady)
`ifdef PARITY_ONES_COUNT_EN
        ,
        .onesCount (onesCount)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int last_wait;

    logic [DW-1:0] frame_q[$];
    bit            mode_m;
    logic [DW-1:0] exp_col, held_col;
    logic          exp_par, held_par;
    int            exp_wc, held_wc, exp_ones, held_ones;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame result from the list of accepted words: XOR, total ones and count.
    function automatic void model_close();
        int ones;
        ones    = 0;
        exp_col = '0;
        foreach (frame_q[i]) begin
            exp_col  = exp_col ^ frame_q[i];
            ones    += $countones(frame_q[i]);
        end
        exp_ones = ones;
        exp_wc   = frame_q.size();
        exp_par  = mode_m ? (ones % 2 == 1) : (ones % 2 == 0);
        frame_q.delete();
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic l, input logic o, output bit ended);
        int n;
        check("held_col", 32'(colParity), 32'(held_col));
        check("held_par", 32'(parityBit), 32'(held_par));
        check("held_wc", 32'(wordCount), 32'(held_wc));
        check("idle_outValid", 32'(outValid), 0);
        inData  = d;
        inLast  = l;
        oddMode = o;
        inValid = 1'b1;
        n = 0;
        while (inReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("inReady_wait", 32'(inReady), 1);
        last_wait = n;
        @(negedge clk);
        inValid = 1'b0;
        inLast  = 1'b0;
        if (frame_q.size() == 0) mode_m = o;
        frame_q.push_back(d);
        ended = l || (frame_q.size() == FL);
        if (ended) model_close();
    endtask

    task automatic check_result(input string tag);
        check({tag, "_outValid"}, 32'(outValid), 1);
        check({tag, "_colParity"}, 32'(colParity), 32'(exp_col));
        check({tag, "_parityBit"}, 32'(parityBit), 32'(exp_par));
        check({tag, "_wordCount"}, 32'(wordCount), 32'(exp_wc));
`ifdef PARITY_ONES_COUNT_EN
        check({tag, "_onesCount"}, 32'(onesCount), 32'(exp_ones));
`endif
    endtask

    task automatic collect(input string tag, input int stall);
        check_result(tag);
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = DW'($urandom);
        inLast   = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_inReady"}, 32'(inReady), 0);
            check_result({tag, "_hold"});
        end
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check({tag, "_xfer_outValid"}, 32'(outValid), 0);
        check({tag, "_xfer_inReady"}, 32'(inReady), 1);
        held_col  = exp_col;
        held_par  = exp_par;
        held_wc   = exp_wc;
        held_ones = exp_ones;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame_q.delete();
        held_col  = '0;
        held_par  = 1'b0;
        held_wc   = 0;
        held_ones = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_outValid"}, 32'(outValid), 0);
        check({tag, "_inReady"}, 32'(inReady), 1);
        check({tag, "_colParity"}, 32'(colParity), 0);
        check({tag, "_parityBit"}, 32'(parityBit), 0);
        check({tag, "_wordCount"}, 32'(wordCount), 0);
`ifdef PARITY_ONES_COUNT_EN
        check({tag, "_onesCount"}, 32'(onesCount), 0);
`endif
    endtask

    initial begin
        bit ended;
        reset    = 1'b1;
        inData   = '0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        oddMode  = 1'b0;
        outReady = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_state("reset");

        // 1-word frame, odd mode
        push(4'b1011, 1'b1, 1'b1, ended);
        collect("one_word", 0);

        // full frame ended by the counter, even mode
        push(4'h1, 1'b0, 1'b0, ended);
        push(4'h2, 1'b0, 1'b1, ended);
        push(4'h4, 1'b0, 1'b1, ended);
        push(4'h8, 1'b0, 1'b1, ended);
        collect("full", 0);

        // back-pressure for 10 cycles, then a new frame right after transfer
        push(4'h5, 1'b1, 1'b0, ended);
        collect("bp", 10);
        push(4'h6, 1'b1, 1'b1, ended);
        check("bp_next_accept_wait", 32'(last_wait), 0);
        collect("bp_next", 0);

        // gaps and early end
        push(4'h3, 1'b0, 1'b1, ended);
        repeat (3) @(negedge clk);
        push(4'h3, 1'b1, 1'b0, ended);
        collect("gap", 2);

        // reset mid-frame
        push(4'h9, 1'b0, 1'b0, ended);
        push(4'h6, 1'b0, 1'b1, ended);
        do_reset();
        check_reset_state("midreset");
        push(4'h7, 1'b1, 1'b1, ended);
        collect("after_reset", 0);

`ifdef PARITY_ONES_COUNT_EN
        push(4'hF, 1'b0, 1'b0, ended);
        push(4'hF, 1'b0, 1'b0, ended);
        push(4'h1, 1'b1, 1'b0, ended);
        collect("ones", 1);
`endif

        for (int f = 0; f < 40; f++) begin
            do begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(DW'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), ended);
            end while (!ended);
            collect("rand", $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
